// File: rtl/word_tokenizer.sv
// ---------------------------------------------------------------------------
// word_tokenizer
//   Splits an incoming text byte stream on whitespace. Each word becomes a
//   {key, value} entry for the downstream word-count stage. The key holds the
//   word left-aligned and zero-padded, and the value is 1. Entries are written
//   through a we/full interface.
//
//   Optional build macro: WORD_TOKENIZER_CASEFOLD_EN
//     When defined, ASCII 'A'..'Z' are folded to 'a'..'z' before packing.
//     Delimiter detection is the same in both builds.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-high reset
//   in_data     input byte
//   in_valid    in_data is valid
//   in_last     final byte of the stream (qualified by in_valid)
//   in_ready    a byte is accepted this cycle when in_valid is also high
//   dout        packed entry {key, value}, stable while we is pending
//   we          write strobe to the downstream buffer
//   full        downstream buffer full; suppresses we
//   word_count  words emitted since reset (wraps)
//   trunc_count words longer than KEY_BYTES (saturates)
//   done        one-cycle pulse after the last word of a stream
//
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module word_tokenizer #(
  parameter int KEY_BYTES   = 16,
  parameter int VALUE_WIDTH = 32,
  parameter int TRUNC_CNT_W = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [7:0]                         in_data,
  input  logic                               in_valid,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic [8*KEY_BYTES+VALUE_WIDTH-1:0] dout,
  output logic                               we,
  input  logic                               full,
  output logic [31:0]                        word_count,
  output logic [TRUNC_CNT_W-1:0]             trunc_count,
  output logic                               done
);

  localparam int KEY_W = 8 * KEY_BYTES;
  localparam int IDX_W = $clog2(KEY_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_SKIP  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [KEY_W-1:0]       key_q, key_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   trunc_q, trunc_d;
  logic                   last_q, last_d;
  logic [31:0]            wc_q, wc_d;
  logic [TRUNC_CNT_W-1:0] tc_q, tc_d;

  logic       accept;
  logic       is_delim;
  logic [7:0] byte_f;

  function automatic logic [7:0] fold_byte(input logic [7:0] b);
`ifdef WORD_TOKENIZER_CASEFOLD_EN
    if (b >= 8'h41 && b <= 8'h5A) begin
      return b + 8'h20;
    end
    return b;
`else
    return b;
`endif
  endfunction

  // Only the three collecting states take input. Reset gates in_ready
  // directly so it reads low for the whole reset interval.
  assign in_ready = ~reset & ((state_q == S_IDLE) || (state_q == S_ACCUM) ||
                              (state_q == S_SKIP));
  assign accept   = in_valid & in_ready;
  assign is_delim = (in_data == 8'h20) || (in_data == 8'h09) ||
                    (in_data == 8'h0A) || (in_data == 8'h0D) ||
                    (in_data == 8'h00);
  assign byte_f   = fold_byte(in_data);

  assign we       = (state_q == S_EMIT) & ~full;
  assign dout     = (state_q == S_EMIT) ? {key_q, VALUE_WIDTH'(1)} : '0;
  assign done     = (state_q == S_DONE);
  assign word_count  = wc_q;
  assign trunc_count = tc_q;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    trunc_d = trunc_q;
    last_d  = last_q;
    wc_d    = wc_q;
    tc_d    = tc_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_delim) begin
            // A stream may end with no word open.
            if (in_last) state_d = S_DONE;
          end else begin
            key_d   = {byte_f, {(KEY_W-8){1'b0}}};
            idx_d   = IDX_W'(1);
            trunc_d = 1'b0;
            if (in_last) begin
              last_d  = 1'b1;
              state_d = S_EMIT;
            end else begin
              state_d = S_ACCUM;
            end
          end
        end
      end

      S_ACCUM: begin
        if (accept) begin
          if (is_delim) begin
            last_d  = in_last;
            state_d = S_EMIT;
          end else begin
            if (idx_q == IDX_W'(KEY_BYTES)) begin
              trunc_d = 1'b1;
            end else begin
              for (int i = 0; i < KEY_BYTES; i++) begin
                if (idx_q == IDX_W'(i)) key_d[KEY_W-8-8*i +: 8] = byte_f;
              end
              idx_d = idx_q + IDX_W'(1);
            end
            if (in_last) begin
              last_d  = 1'b1;
              state_d = S_EMIT;
            end else if (idx_q == IDX_W'(KEY_BYTES)) begin
              state_d = S_SKIP;
            end
          end
        end
      end

      S_SKIP: begin
        if (accept && (is_delim || in_last)) begin
          last_d  = in_last;
          state_d = S_EMIT;
        end
      end

      S_EMIT: begin
        if (!full) begin
          wc_d = wc_q + 32'd1;
          if (trunc_q && (tc_q != {TRUNC_CNT_W{1'b1}})) begin
            tc_d = tc_q + TRUNC_CNT_W'(1);
          end
          key_d   = '0;
          idx_d   = '0;
          trunc_d = 1'b0;
          last_d  = 1'b0;
          state_d = last_q ? S_DONE : S_IDLE;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      trunc_q <= 1'b0;
      last_q  <= 1'b0;
      wc_q    <= '0;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      trunc_q <= trunc_d;
      last_q  <= last_d;
      wc_q    <= wc_d;
      tc_q    <= tc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_word_tokenizer.sv
// ---------------------------------------------------------------------------
// tb_word_tokenizer
//   Self-checking bench for word_tokenizer. A queue-based word-splitting model
//   predicts every entry. A compare process checks each write, the counters
//   and the done pulses. Directed tests add hand-computed literals.
//
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_word_tokenizer;

  localparam int KB = 16;
  localparam int VW = 32;
  localparam int TW = 16;
  localparam int DW = 8*KB + VW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          full = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dout;
  logic          we;
  logic [31:0]   word_count;
  logic [TW-1:0] trunc_count;
  logic          done;

  always #5 clk = ~clk;

  word_tokenizer #(.KEY_BYTES(KB), .VALUE_WIDTH(VW), .TRUNC_CNT_W(TW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .dout(dout), .we(we),
    .full(full), .word_count(word_count), .trunc_count(trunc_count),
    .done(done)
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [DW-1:0] ent;
    bit            trunc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] cur[$];
  int exp_done = 0, done_cnt = 0, wr_cnt = 0, trunc_wr = 0;
  int cyc = 0, last_we_cyc = -10, done_cyc = -20;
  logic [DW-1:0] first_dout = '0, last_dout = '0;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] mfold(input logic [7:0] b);
`ifdef WORD_TOKENIZER_CASEFOLD_EN
    if (b >= "A" && b <= "Z") return b - "A" + "a";
`endif
    return b;
  endfunction

  task automatic model_flush();
    exp_t e;
    logic [8*KB-1:0] k;
    k = '0;
    if (cur.size() == 0) return;
    for (int i = 0; i < cur.size() && i < KB; i++)
      k[8*KB-1-8*i -: 8] = mfold(cur[i]);
    e.ent   = {k, 32'd1};
    e.trunc = (cur.size() > KB);
    exp_q.push_back(e);
    cur.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit last);
    bit delim;
    delim = (b inside {8'h20, 8'h09, 8'h0A, 8'h0D, 8'h00});
    if (!delim) cur.push_back(b);
    if (delim || last) model_flush();
    if (last) exp_done++;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      exp_t e;
      cyc++;
      check("we_while_full", {{(DW-1){1'b0}}, we & full}, '0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (we) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_write: got %h expected no write", dout);
        end else begin
          e = exp_q.pop_front();
          check("dout", dout, e.ent);
          check("word_count_pre", DW'(word_count), DW'(wr_cnt));
          if (e.trunc) trunc_wr++;
        end
        if (wr_cnt == 0) first_dout = dout;
        last_dout   = dout;
        last_we_cyc = cyc;
        wr_cnt++;
      end else begin
        check("trunc_count", DW'(trunc_count), DW'(trunc_wr));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b, input bit last);
    int n;
    model_byte(b, last);
    in_data  = b;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 100 cycles");
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_on_final);
    for (int i = 0; i < s.len(); i++)
      send(s[i], last_on_final && (i == s.len() - 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    cur.delete();
    #1;
    check("rst_in_ready", DW'(in_ready), '0);
    check("rst_we", DW'(we), '0);
    check("rst_dout", dout, '0);
    check("rst_wc", DW'(word_count), '0);
    check("rst_tc", DW'(trunc_count), '0);
    check("rst_done", DW'(done), '0);
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    wr_cnt   = 0;
    trunc_wr = 0;
    done_cnt = 0;
    exp_done = 0;
    #1;
    check("in_ready_after_rst", DW'(in_ready), DW'(1));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [DW-1:0] lit;

    // "the cat", last on the final 't'
    do_reset();
    send_str("the cat", 1'b1);
    drain();
    check("tc1_first", first_dout, 160'h74686500_00000000_00000000_00000000_00000001);
    check("tc1_last", last_dout, 160'h63617400_00000000_00000000_00000000_00000001);
    check("tc1_writes", DW'(wr_cnt), DW'(2));
    check("tc1_wc", DW'(word_count), DW'(2));
    check("tc1_tc", DW'(trunc_count), '0);
    check("tc1_done_cnt", DW'(done_cnt), DW'(1));
    check("tc1_done_timing", DW'(done_cyc), DW'(last_we_cyc + 1));

    // runs of delimiters
    do_reset();
    send_str("  a\n\nb ", 1'b1);
    drain();
    check("tc2_first", first_dout, 160'h61000000_00000000_00000000_00000000_00000001);
    check("tc2_last", last_dout, 160'h62000000_00000000_00000000_00000000_00000001);
    check("tc2_wc", DW'(word_count), DW'(2));
    check("tc2_done_cnt", DW'(done_cnt), DW'(exp_done));

    // 20-byte word gets truncated to 16
    do_reset();
    send_str("abcdefghijklmnopqrst ", 1'b1);
    drain();
    check("tc3_key", last_dout, 160'h61626364_65666768_696a6b6c_6d6e6f70_00000001);
    check("tc3_wc", DW'(word_count), DW'(1));
    check("tc3_tc", DW'(trunc_count), DW'(1));

    // exactly 16 bytes is not truncated
    do_reset();
    send_str("abcdefghijklmnop\t", 1'b1);
    drain();
    check("tc4_key", last_dout, 160'h61626364_65666768_696a6b6c_6d6e6f70_00000001);
    check("tc4_tc", DW'(trunc_count), '0);
    check("tc4_wc", DW'(word_count), DW'(1));

    // back-pressure during EMIT
    do_reset();
    full = 1'b1;
    send_str("hi ", 1'b0);
    lit = 160'h68690000_00000000_00000000_00000000_00000001;
    for (int i = 0; i < 10; i++) begin
      check("tc5_we_held", DW'(we), '0);
      check("tc5_ready_held", DW'(in_ready), '0);
      check("tc5_dout_held", dout, lit);
      @(negedge clk);
    end
    @(posedge clk);
    #1 full = 1'b0;
    @(negedge clk);
    drain();
    check("tc5_writes", DW'(wr_cnt), DW'(1));
    check("tc5_wc", DW'(word_count), DW'(1));

    // asynchronous reset while stalled in EMIT
    full = 1'b1;
    send_str("xyz ", 1'b0);
    check("tc6_wc_before", DW'(word_count), DW'(1));
    #2 reset = 1'b1;
    exp_q.delete();
    cur.delete();
    #1;
    check("tc6_we", DW'(we), '0);
    check("tc6_dout", dout, '0);
    check("tc6_wc", DW'(word_count), '0);
    check("tc6_ready", DW'(in_ready), '0);
    check("tc6_done", DW'(done), '0);
    full = 1'b0;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    wr_cnt   = 0;
    trunc_wr = 0;
    done_cnt = 0;
    exp_done = 0;
    repeat (5) @(negedge clk);
    check("tc6_no_write", DW'(wr_cnt), '0);
    check("tc6_wc_after", DW'(word_count), '0);

    // case folding (build dependent)
    do_reset();
    send_str("Cat", 1'b1);
    drain();
`ifdef WORD_TOKENIZER_CASEFOLD_EN
    lit = 160'h63617400_00000000_00000000_00000000_00000001;
`else
    lit = 160'h43617400_00000000_00000000_00000000_00000001;
`endif
    check("tc7_key", last_dout, lit);

    // in_last on a delimiter with no word open
    do_reset();
    send(8'h20, 1'b1);
    drain();
    check("tc8_done_cnt", DW'(done_cnt), DW'(1));
    check("tc8_writes", DW'(wr_cnt), '0);
    check("tc8_wc", DW'(word_count), '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/word_tokenizer.md
Name: word_tokenizer

Overview:
- Upstream feeder for the word-count search/accumulate stage.
- Accepts a byte stream of text and splits it on whitespace.
- Each word is packed into a 128-bit key, left-aligned and zero-padded, with a 32-bit value of 1.
- The resulting 160-bit entry is written into the downstream stage's input buffer using the we/full write interface.

Parameters:
- KEY_BYTES, 16, maximum bytes per key; key width = 8*KEY_BYTES.
- VALUE_WIDTH, 32, width of the value field carried with each key.
- TRUNC_CNT_W, 16, width of the truncated-word counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  input byte.
- in_valid  in  1  in_data is valid.
- in_last  in  1  qualifies the final byte of the stream; sampled with in_valid.
- in_ready  out  1  tokenizer accepts a byte this cycle.
- dout  out  8*KEY_BYTES+VALUE_WIDTH  packed entry: {key, value}.
- we  out  1  write strobe to the downstream buffer.
- full  in  1  downstream buffer full; no write may occur while high.
- word_count  out  32  total words emitted since reset.
- trunc_count  out  TRUNC_CNT_W  words longer than KEY_BYTES; saturating.
- done  out  1  one-cycle pulse after the last word of a stream has been written.

Behaviour:
- Reset (asynchronous assert) clears all state and outputs:
  - in_ready=0 while reset is high, 1 on the first cycle after release.
  - dout=0, we=0, word_count=0, trunc_count=0, done=0.
  - FSM goes to IDLE.
- Byte acceptance: a byte is accepted on a clock edge where in_valid & in_ready.
- Delimiters: 0x20, 0x09, 0x0A, 0x0D, 0x00. All other bytes are word bytes.
- Key packing:
  - The first byte of a word goes to key[8*KEY_BYTES-1 -: 8], the next byte 8 bits lower, and so on.
  - Unused low bytes are 0.
  - value = 1, zero-extended to VALUE_WIDTH.
- FSM states:
  - IDLE: delimiter -> stay. Word byte -> load byte 0, byte index=1, go ACCUM.
  - ACCUM:
    - Word byte with index<KEY_BYTES -> store byte, index+1.
    - Word byte with index==KEY_BYTES -> go SKIP; the word is flagged truncated.
    - Delimiter -> go EMIT.
  - SKIP: word bytes are discarded. Delimiter -> go EMIT.
  - EMIT:
    - in_ready=0.
    - we = ~full (combinational from state and full); dout is held stable.
    - On the edge where we=1:
      - word_count +1 (32-bit, wraps).
      - trunc_count +1 if the word was flagged truncated (saturates at all-ones).
      - Key register cleared.
      - Next state: IDLE, or DONE if in_last was seen.
    - While full=1: hold EMIT and dout indefinitely; we=0.
  - DONE: done=1 for exactly one cycle, in_ready=0, then IDLE.
- in_last handling:
  - On a word byte with in_last: store the byte if room (or drop and flag truncation if not), then EMIT with a last flag.
  - On a delimiter with in_last while in ACCUM/SKIP: EMIT with the last flag.
  - With in_last while in IDLE (no word open): go directly to DONE.
- Latency: a terminating byte accepted at edge N gives we=1 during cycle N+1 if full=0.
- Throughput: one byte per cycle, except one stall cycle per word emitted, plus stalls while full is high.
- No entry is ever emitted for an empty word. Consecutive delimiters produce nothing.
- Reset mid-operation (including mid-EMIT with full high): the partial word is discarded, no write occurs, and the counters clear.

Optional Feature:
- Macro: WORD_TOKENIZER_CASEFOLD_EN.
- Defined: bytes 0x41-0x5A are converted to 0x61-0x7A before packing, so "The" and "the" produce identical keys.
- Undefined: bytes are packed unmodified.
- Delimiter detection is identical in both builds.

Test Plan:
- Stream "the cat" (last on 't'), full=0 -> exactly two writes:
  - 0x74686500_00000000_00000000_00000000_00000001
  - 0x63617400_..._00000001
  - Then word_count=2, trunc_count=0, and done pulses one cycle after the second write.
- Stream "  a\n\nb " with multiple delimiters -> exactly two writes, keys 0x61000... and 0x62000..., no empty entries.
- A 20-byte word "abcdefghijklmnopqrst" followed by a space -> one write with key "abcdefghijklmnop" (0x6162...6F70), trunc_count=1, word_count=1.
- Exactly 16-byte word followed by a delimiter -> full key, trunc_count=0.
- full held high for 10 cycles during EMIT:
  - we=0, in_ready=0, dout stable throughout.
  - Single write on the first cycle full=0; no duplicate write.
- reset asserted while in EMIT with full=1 -> all outputs go 0 immediately (asynchronously); after release, word_count=0 and no write of the discarded word.
- With WORD_TOKENIZER_CASEFOLD_EN defined, "Cat" -> key 0x636174...; undefined -> 0x436174....
